// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, address-mode enum and bit-reverse helper
package fft_pkg;

  localparam int LOG2N   = 5;
  localparam int N       = 1 << LOG2N;
  localparam int ADDR_W  = LOG2N + 2;
  localparam int TW_BASE = 2 * N;
  localparam int K_W     = LOG2N - 1;
  localparam int S_W     = $clog2(LOG2N);
  localparam int CNT_W   = LOG2N + 2;

  typedef enum logic [1:0] {
    MODE_INPUT   = 2'd0,
    MODE_TWIDDLE = 2'd1,
    MODE_BFLY    = 2'd2,
    MODE_OUTPUT  = 2'd3
  } addr_mode_e;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_index.sv
// rtl/fft_bfly_index.sv - radix-2 butterfly operand indices and twiddle index from stage/butterfly
module fft_bfly_index
  import fft_pkg::*;
(
  input  logic [S_W-1:0]   i_s,
  input  logic [K_W-1:0]   i_k,
  output logic [LOG2N-1:0] o_idx_a,
  output logic [LOG2N-1:0] o_idx_b,
  output logic [K_W-1:0]   o_tw
);

  logic [LOG2N-1:0] w_k;
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_grp;
  logic [S_W-1:0]   w_tw_sh;

  assign w_k     = LOG2N'(i_k);
  assign w_span  = LOG2N'(1) << i_s;
  assign w_pos   = w_k & (w_span - LOG2N'(1));
  assign w_grp   = w_k >> i_s;
  assign o_idx_a = (w_grp << (i_s + S_W'(1))) | w_pos;
  assign o_idx_b = o_idx_a + w_span;

  // pos < span, so the shifted twiddle index always fits in K_W bits
  assign w_tw_sh = S_W'(LOG2N - 1) - i_s;
  assign o_tw    = K_W'(w_pos << w_tw_sh);

endmodule

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - SRAM word address generator for an in-place radix-2 FFT
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              sram_read_ena,
  input  logic              sram_write_ena,
  input  logic              shift_in_ena,
  input  logic              shift_out_ena,
  input  logic [1:0]        addr_mode,
  input  logic              k_ena,
  input  logic              k_clear,
  input  logic              iteration_ena,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [2:0]        samples_loaded_count,
  output logic              samples_loaded_done,
  output logic              samples_written_done,
  output logic              samples_in_done,
  output logic              samples_out_done,
  output logic              iteration_done,
  output logic              fft_done
);

  logic [CNT_W-1:0]  r_in_cnt;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [2:0]        r_rd_cnt;
  logic [2:0]        r_wr_cnt;
  logic [1:0]        r_tw_cnt;
  logic [K_W-1:0]    r_k;
  logic [S_W-1:0]    r_s;
  logic              r_iter_done;
  logic              r_fft_done;
  logic [ADDR_W-1:0] r_last_addr;

  addr_mode_e        w_mode;
  logic [LOG2N-1:0]  w_idx_a;
  logic [LOG2N-1:0]  w_idx_b;
  logic [K_W-1:0]    w_tw;
  logic              w_in_full;
  logic              w_out_full;
  logic              w_rd_full;
  logic              w_wr_full;
  logic              w_tw_full;
  logic              w_in_inc;
  logic              w_out_inc;
  logic              w_rd_inc;
  logic              w_wr_inc;
  logic              w_tw_inc;
  logic              w_svc;
  logic [1:0]        w_sel;
  logic [ADDR_W-1:0] w_addr_calc;
  logic              w_unused;

  // shift strobes are observed by the MCU only; they never move the address state
  assign w_unused = &{1'b0, shift_in_ena, shift_out_ena};

  assign w_mode = addr_mode_e'(addr_mode);

  fft_bfly_index u_bfly_index (
    .i_s     (r_s),
    .i_k     (r_k),
    .o_idx_a (w_idx_a),
    .o_idx_b (w_idx_b),
    .o_tw    (w_tw)
  );

  assign w_in_full  = (r_in_cnt == CNT_W'(2 * N));
  assign w_out_full = (r_out_cnt == CNT_W'(2 * N));
  assign w_rd_full  = (r_rd_cnt == 3'd4);
  assign w_wr_full  = (r_wr_cnt == 3'd4);
  assign w_tw_full  = (r_tw_cnt == 2'd2);

  always_comb begin
    w_in_inc    = 1'b0;
    w_out_inc   = 1'b0;
    w_rd_inc    = 1'b0;
    w_wr_inc    = 1'b0;
    w_tw_inc    = 1'b0;
    w_sel       = r_rd_cnt[1:0];
    w_addr_calc = r_last_addr;
    case (w_mode)
      MODE_INPUT: begin
        w_in_inc    = sram_write_ena && !w_in_full;
        w_addr_calc = ADDR_W'({bitrev(r_in_cnt[LOG2N:1]), r_in_cnt[0]});
      end
      MODE_TWIDDLE: begin
        w_tw_inc    = sram_read_ena && !w_tw_full;
        w_addr_calc = ADDR_W'(TW_BASE) + ADDR_W'({w_tw, r_tw_cnt[0]});
      end
      MODE_BFLY: begin
        // a simultaneous write wins the port; the read is dropped entirely
        w_wr_inc    = sram_write_ena && !w_wr_full;
        w_rd_inc    = sram_read_ena && !sram_write_ena && !w_rd_full;
        w_sel       = sram_write_ena ? r_wr_cnt[1:0] : r_rd_cnt[1:0];
        w_addr_calc = ADDR_W'({(w_sel[1] ? w_idx_b : w_idx_a), w_sel[0]});
      end
      MODE_OUTPUT: begin
        w_out_inc   = sram_read_ena && !w_out_full;
        w_addr_calc = ADDR_W'(r_out_cnt);
      end
      default: begin
        w_addr_calc = r_last_addr;
      end
    endcase
  end

  assign w_svc     = w_in_inc | w_out_inc | w_rd_inc | w_wr_inc | w_tw_inc;
  assign sram_addr = w_svc ? w_addr_calc : r_last_addr;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_tw_cnt    <= '0;
      r_k         <= '0;
      r_s         <= '0;
      r_iter_done <= 1'b0;
      r_fft_done  <= 1'b0;
      r_last_addr <= '0;
    end else begin
      r_iter_done <= 1'b0;
      if (w_svc) r_last_addr <= w_addr_calc;
      if (w_in_inc)  r_in_cnt  <= r_in_cnt + CNT_W'(1);
      if (w_out_inc) r_out_cnt <= r_out_cnt + CNT_W'(1);
      if (w_rd_inc)  r_rd_cnt  <= r_rd_cnt + 3'd1;
      if (w_wr_inc)  r_wr_cnt  <= r_wr_cnt + 3'd1;
      if (w_tw_inc)  r_tw_cnt  <= r_tw_cnt + 2'd1;

      // control strobes override any counter advance in the same cycle
      if (k_clear) begin
        r_k        <= '0;
        r_s        <= '0;
        r_rd_cnt   <= '0;
        r_wr_cnt   <= '0;
        r_tw_cnt   <= '0;
        r_in_cnt   <= '0;
        r_out_cnt  <= '0;
        r_fft_done <= 1'b0;
      end else if (iteration_ena) begin
        r_k      <= '0;
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
        r_tw_cnt <= '0;
        if (r_s == S_W'(LOG2N - 1)) r_fft_done <= 1'b1;
        else                        r_s        <= r_s + S_W'(1);
      end else if (k_ena) begin
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
        r_tw_cnt <= '0;
        if (r_k == K_W'(N / 2 - 1)) begin
          r_k         <= '0;
          r_iter_done <= 1'b1;
        end else begin
          r_k <= r_k + K_W'(1);
        end
      end
    end
  end

  assign samples_loaded_count = r_rd_cnt;
  assign samples_loaded_done  = w_rd_full;
  assign samples_written_done = w_wr_full;
  assign samples_in_done      = w_in_full;
  assign samples_out_done     = w_out_full;
  assign iteration_done       = r_iter_done;
  assign fft_done             = r_fft_done;

endmodule
